// File: rtl/my_pkg.sv
// my_pkg: operation encoding, BHT counter type and small helpers shared by
// the branch resolve unit and its branch history table.
package my_pkg;

   typedef enum logic [2:0] {
      OP0 = 3'd0,   // beq
      OP1 = 3'd1,   // bne
      OP2 = 3'd2,   // blt  (signed)
      OP3 = 3'd3,   // bltu (unsigned)
      OP4 = 3'd4,   // bge  (signed)
      OP5 = 3'd5,   // bgeu (unsigned)
      OP6 = 3'd6,   // jal  (opA = PC, opB = offset)
      OP7 = 3'd7    // jalr
   } instruction_type;

   typedef logic [1:0] bht_ctr_t;

   // Weakly not-taken: one taken outcome is enough to flip the prediction.
   localparam bht_ctr_t BHT_CTR_RESET = 2'b01;

   function automatic logic is_cond_branch(input instruction_type op);
      return (op inside {OP0, OP1, OP2, OP3, OP4, OP5});
   endfunction

   // Two-bit saturating counter step.
   function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t ctr, input logic taken);
      if (taken)
         return (ctr == 2'b11) ? ctr : ctr + 2'd1;
      else
         return (ctr == 2'b00) ? ctr : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/bru_bht.sv
// bru_bht: branch history table of 2-bit saturating counters.
// One combinational read port (fetch prediction) and one synchronous update
// port (execute resolution). A read of the entry being updated in the same
// cycle returns the pre-update value.
module bru_bht
   import my_pkg::*;
#(
   parameter int BHT_DEPTH = 64,
   parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   bht_ctr_t ctr [BHT_DEPTH];

   // Prediction is the counter's upper bit.
   assign rd_taken = ctr[rd_idx][1];

   // Counter array: reinitialise to weakly not-taken, step on resolved branches.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < BHT_DEPTH; k++) begin
            ctr[k] <= BHT_CTR_RESET;
         end
      end else if (upd_en) begin
         ctr[upd_idx] <= bht_ctr_next(ctr[upd_idx], upd_taken);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: execute-stage resolution of conditional branches,
// JAL and JALR with a one-cycle registered result, misprediction redirect
// and misaligned-target detection.
// Build option: define BRU_BHT_EN to instantiate the branch history table
// (bru_bht); without it lookup_taken is a static not-taken 0.
module branch_resolve_unit
   import my_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int IDX_LSB   = 2
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            valid_in,
   input  logic            flush_in,
   input  instruction_type i,
   input  logic [XLEN-1:0] opA,
   input  logic [XLEN-1:0] opB,
   input  logic [XLEN-1:0] offset,
   input  logic [XLEN-1:0] NPC,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            lookup_taken,
   output logic            valid_out,
   output logic [XLEN-1:0] result_out,
   output logic [XLEN-1:0] result_jal,
   output logic            jump_out,
   output logic            we_out,
   output logic            redirect_out,
   output logic [XLEN-1:0] redirect_pc,
   output logic            misalign_out
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic                   acc;
   logic signed [XLEN-1:0] opa_s;
   logic signed [XLEN-1:0] opb_s;
   logic        [XLEN-1:0] sum_ab;
   logic        [XLEN-1:0] target;
   logic        [XLEN-1:0] link;
   logic                   jump;
   logic                   is_jump;
   logic                   branch_class;
   logic                   mis;

   logic                   vld_p1;
   logic                   jump_p1;
   logic                   we_p1;
   logic                   redirect_p1;
   logic                   mis_p1;
   logic        [XLEN-1:0] result_p1;
   logic        [XLEN-1:0] jal_p1;
   logic        [XLEN-1:0] rpc_p1;

   // Fetch PC only feeds the BHT index; the remaining bits are intentionally dropped.
   logic unused_lookup_bits;
   assign unused_lookup_bits = ^lookup_pc;

   assign acc   = valid_in & ~flush_in;
   assign opa_s = opA;
   assign opb_s = opB;

   // Resolve condition, target and link address for the presented instruction.
   always_comb begin
      sum_ab  = opA + opB;
      target  = NPC + offset;
      link    = NPC + XLEN'(4);
      jump    = 1'b0;
      is_jump = 1'b0;
      case (i)
         OP0: jump = (opA == opB);
         OP1: jump = (opA != opB);
         OP2: jump = (opa_s <  opb_s);
         OP3: jump = (opA   <  opB);
         OP4: jump = (opa_s >= opb_s);
         OP5: jump = (opA   >= opB);
         OP6: begin
            target  = sum_ab;
            jump    = 1'b1;
            is_jump = 1'b1;
         end
         OP7: begin
            target  = {sum_ab[XLEN-1:1], 1'b0};
            jump    = 1'b1;
            is_jump = 1'b1;
         end
         default: ;
      endcase
      branch_class = is_cond_branch(i) | is_jump;
      // A taken target off a 4-byte boundary goes to the trap unit instead.
      mis = acc & jump & target[1];
   end

   // ---- execute -> result register (p1) ----
   // Register the resolved result; rejected cycles register all zeros.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p1      <= 1'b0;
         jump_p1     <= 1'b0;
         we_p1       <= 1'b0;
         redirect_p1 <= 1'b0;
         mis_p1      <= 1'b0;
         result_p1   <= '0;
         jal_p1      <= '0;
         rpc_p1      <= '0;
      end else begin
         vld_p1      <= acc;
         jump_p1     <= acc & jump;
         we_p1       <= acc & is_jump & ~mis;
         redirect_p1 <= acc & branch_class & (jump != pred_taken) & ~mis;
         mis_p1      <= mis;
         result_p1   <= acc ? target : '0;
         jal_p1      <= (acc & is_jump) ? link : '0;
         rpc_p1      <= acc ? (jump ? target : link) : '0;
      end
   end

   assign valid_out    = vld_p1;
   assign jump_out     = jump_p1;
   assign we_out       = we_p1;
   assign redirect_out = redirect_p1;
   assign misalign_out = mis_p1;
   assign result_out   = result_p1;
   assign result_jal   = jal_p1;
   assign redirect_pc  = rpc_p1;

`ifdef BRU_BHT_EN
   logic upd_en;
   assign upd_en = acc & is_cond_branch(i);

   bru_bht #(
      .BHT_DEPTH (BHT_DEPTH),
      .IDX_W     (IDX_W)
   ) u_bht (
      .clk       (clk),
      .rstn      (rstn),
      .rd_idx    (lookup_pc[IDX_LSB +: IDX_W]),
      .rd_taken  (lookup_taken),
      .upd_en    (upd_en),
      .upd_idx   (NPC[IDX_LSB +: IDX_W]),
      .upd_taken (jump)
   );
`else
   // Static not-taken prediction when no history is kept.
   assign lookup_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and randomized checks of the branch
// resolve unit against a behavioural model (outcome rules, integer BHT).
module tb_branch_resolve_unit;
   import my_pkg::*;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            valid_in = 1'b0;
   logic            flush_in = 1'b0;
   instruction_type op = OP0;
   logic [31:0]     opA = '0;
   logic [31:0]     opB = '0;
   logic [31:0]     offset = '0;
   logic [31:0]     NPC = '0;
   logic            pred_taken = 1'b0;
   logic [31:0]     lookup_pc = '0;
   logic            lookup_taken;
   logic            valid_out;
   logic [31:0]     result_out;
   logic [31:0]     result_jal;
   logic            jump_out;
   logic            we_out;
   logic            redirect_out;
   logic [31:0]     redirect_pc;
   logic            misalign_out;

   int errors = 0;
   int checks = 0;
   int bht [64];

   typedef struct packed {
      logic        vld;
      logic        jmp;
      logic        we;
      logic        red;
      logic        mis;
      logic [31:0] res;
      logic [31:0] jal;
      logic [31:0] rpc;
   } exp_t;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64), .IDX_LSB(2)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .valid_in     (valid_in),
      .flush_in     (flush_in),
      .i            (op),
      .opA          (opA),
      .opB          (opB),
      .offset       (offset),
      .NPC          (NPC),
      .pred_taken   (pred_taken),
      .lookup_pc    (lookup_pc),
      .lookup_taken (lookup_taken),
      .valid_out    (valid_out),
      .result_out   (result_out),
      .result_jal   (result_jal),
      .jump_out     (jump_out),
      .we_out       (we_out),
      .redirect_out (redirect_out),
      .redirect_pc  (redirect_pc),
      .misalign_out (misalign_out)
   );

   function automatic exp_t observed();
      return {valid_out, jump_out, we_out, redirect_out, misalign_out,
              result_out, result_jal, redirect_pc};
   endfunction

   // Reference outcome from the instruction-set rules.
   function automatic exp_t model(input int o, input logic [31:0] a, b, off, npc,
                                  input logic pt, input logic acc);
      exp_t e;
      logic [31:0] tgt;
      logic tk;
      e = '0;
      if (!acc) return e;
      case (o)
         0: tk = (a == b);
         1: tk = (a != b);
         2: tk = (int'(a) < int'(b));
         3: tk = (a < b);
         4: tk = (int'(a) >= int'(b));
         5: tk = (a >= b);
         default: tk = 1'b1;
      endcase
      if (o == 6)      tgt = a + b;
      else if (o == 7) tgt = (a + b) & 32'hFFFF_FFFE;
      else             tgt = npc + off;
      e.vld = 1'b1;
      e.jmp = tk;
      e.res = tgt;
      e.jal = (o >= 6) ? npc + 32'd4 : 32'd0;
      e.mis = tk & tgt[1];
      e.we  = (o >= 6) & ~e.mis;
      e.red = (tk != pt) & ~e.mis;
      e.rpc = tk ? tgt : npc + 32'd4;
      return e;
   endfunction

   function automatic int bidx(input logic [31:0] pc);
      return int'((pc >> 2) & 32'd63);
   endfunction

   function automatic logic model_lookup(input logic [31:0] pc);
`ifdef BRU_BHT_EN
      return bht[bidx(pc)] >= 2;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_update(input int o, input logic [31:0] npc, input logic tk, input logic acc);
      if (acc && o <= 5) begin
         if (tk) bht[bidx(npc)] = (bht[bidx(npc)] == 3) ? 3 : bht[bidx(npc)] + 1;
         else    bht[bidx(npc)] = (bht[bidx(npc)] == 0) ? 0 : bht[bidx(npc)] - 1;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 64; k++) bht[k] = 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input instruction_type o, input logic [31:0] a, b, off, npc,
                        input logic pt, input logic vld, input logic fl);
      op = o; opA = a; opB = b; offset = off; NPC = npc;
      pred_taken = pt; valid_in = vld; flush_in = fl;
   endtask

   // Present one instruction for one cycle, update the model, leave the bus idle.
   task automatic issue(input instruction_type o, input logic [31:0] a, b, off, npc,
                        input logic pt, input logic vld, input logic fl, output exp_t e);
      drive(o, a, b, off, npc, pt, vld, fl);
      e = model(int'(o), a, b, off, npc, pt, vld & ~fl);
      model_update(int'(o), npc, e.jmp, vld & ~fl);
      tick();
      valid_in = 1'b0;
      flush_in = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      tick();
      checks++;
      if (observed() !== exp_t'('0)) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", observed());
      end
      lookup_pc = 32'h100;
      #1;
      checks++;
      if (lookup_taken !== 1'b0) begin
         errors++;
         $display("FAIL reset_lookup_100: got %b expected 0", lookup_taken);
      end
      lookup_pc = 32'hFFC;
      #1;
      checks++;
      if (lookup_taken !== 1'b0) begin
         errors++;
         $display("FAIL reset_lookup_ffc: got %b expected 0", lookup_taken);
      end
      tick();
   endtask

   task automatic test_beq_taken();
      exp_t e;
      issue(OP0, 32'd5, 32'd5, 32'h40, 32'h1000, 1'b0, 1'b1, 1'b0, e);
      checks++;
      if (jump_out !== 1'b1 || result_out !== 32'h1040) begin
         errors++;
         $display("FAIL beq_target: got jump=%b res=%h expected jump=1 res=00001040", jump_out, result_out);
      end
      checks++;
      if (redirect_out !== 1'b1 || redirect_pc !== 32'h1040) begin
         errors++;
         $display("FAIL beq_redirect: got red=%b pc=%h expected red=1 pc=00001040", redirect_out, redirect_pc);
      end
      checks++;
      if (observed() !== e) begin
         errors++;
         $display("FAIL beq_all: got %h expected %h", observed(), e);
      end
      lookup_pc = 32'h1000;
      #1;
      checks++;
      if (lookup_taken !== model_lookup(32'h1000)) begin
         errors++;
         $display("FAIL beq_bht_lookup: got %b expected %b", lookup_taken, model_lookup(32'h1000));
      end
      tick();
      checks++;
      if (valid_out !== 1'b0 || redirect_out !== 1'b0) begin
         errors++;
         $display("FAIL beq_one_cycle: got valid=%b red=%b expected 0 0", valid_out, redirect_out);
      end
   endtask

   task automatic test_jalr_misalign();
      exp_t e;
      issue(OP7, 32'h2001, 32'h6, 32'h0, 32'h300, 1'b0, 1'b1, 1'b0, e);
      checks++;
      if (result_out !== 32'h2006 || result_jal !== 32'h304) begin
         errors++;
         $display("FAIL jalr_addr: got res=%h jal=%h expected res=00002006 jal=00000304", result_out, result_jal);
      end
      checks++;
      if (misalign_out !== 1'b1 || redirect_out !== 1'b0 || we_out !== 1'b0) begin
         errors++;
         $display("FAIL jalr_misalign: got mis=%b red=%b we=%b expected mis=1 red=0 we=0",
                  misalign_out, redirect_out, we_out);
      end
      // Aligned JAL: link written, redirect since predicted not-taken.
      issue(OP6, 32'h500, 32'h80, 32'h0, 32'h500, 1'b0, 1'b1, 1'b0, e);
      checks++;
      if (observed() !== e || we_out !== 1'b1 || redirect_pc !== 32'h580) begin
         errors++;
         $display("FAIL jal_aligned: got %h expected %h", observed(), e);
      end
   endtask

   task automatic test_signed_unsigned();
      exp_t e;
      issue(OP2, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h400, 1'b0, 1'b1, 1'b0, e);
      checks++;
      if (jump_out !== 1'b1 || observed() !== e) begin
         errors++;
         $display("FAIL blt_signed: got %h expected %h", observed(), e);
      end
      issue(OP3, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h400, 1'b1, 1'b1, 1'b0, e);
      checks++;
      if (jump_out !== 1'b0 || redirect_out !== 1'b1 || redirect_pc !== 32'h404) begin
         errors++;
         $display("FAIL bltu_unsigned: got jump=%b red=%b pc=%h expected jump=0 red=1 pc=00000404",
                  jump_out, redirect_out, redirect_pc);
      end
   endtask

   task automatic test_saturation();
      exp_t e;
      for (int n = 0; n < 6; n++) begin
         // five not-taken (equal operands) then one taken
         issue(OP1, 32'd7, (n < 5) ? 32'd7 : 32'd8, 32'h10, 32'h2008, 1'b0, 1'b1, 1'b0, e);
         lookup_pc = 32'h2008;
         #1;
         checks++;
         if (lookup_taken !== model_lookup(32'h2008) || observed() !== e) begin
            errors++;
            $display("FAIL saturation_step%0d: got look=%b out=%h expected look=%b out=%h",
                     n, lookup_taken, observed(), model_lookup(32'h2008), e);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      exp_t e;
      issue(OP6, 32'h600, 32'h40, 32'h0, 32'h600, 1'b0, 1'b1, 1'b1, e);
      checks++;
      if (valid_out !== 1'b0 || redirect_out !== 1'b0 || observed() !== exp_t'('0)) begin
         errors++;
         $display("FAIL flush_jal: got %h expected 0", observed());
      end
      for (int n = 0; n < 3; n++) issue(OP0, 32'd3, 32'd3, 32'h8, 32'h3010, 1'b0, 1'b1, 1'b1, e);
      lookup_pc = 32'h3010;
      #1;
      checks++;
      if (lookup_taken !== model_lookup(32'h3010) || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL flush_bht: got look=%b valid=%b expected look=%b valid=0",
                  lookup_taken, valid_out, model_lookup(32'h3010));
      end
      tick();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic el;
      instruction_type o;
      logic [31:0] a, b, off, npc;
      logic vld, fl, pt;
      for (int n = 0; n < 400; n++) begin
         o   = instruction_type'($urandom_range(0, 7));
         a   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
         b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom
                                                   : 32'($urandom_range(0, 8)) - 32'd4);
         off = 32'($urandom_range(0, 255)) << 1;
         npc = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
         vld = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 4) == 0);
         pt  = ($urandom_range(0, 1) == 0) ? model_lookup(npc) : 1'($urandom_range(0, 1));
         drive(o, a, b, off, npc, pt, vld, fl);
         lookup_pc = ($urandom_range(0, 1) == 0) ? npc : 32'h1000 + (32'($urandom_range(0, 15)) << 2);
         e  = model(int'(o), a, b, off, npc, pt, vld & ~fl);
         el = model_lookup(lookup_pc);
         #1;
         checks++;
         if (lookup_taken !== el) begin
            errors++;
            $display("FAIL rand_lookup%0d: got %b expected %b", n, lookup_taken, el);
         end
         model_update(int'(o), npc, e.jmp, vld & ~fl);
         @(posedge clk);
         #1;
         checks++;
         if (observed() !== e) begin
            errors++;
            $display("FAIL rand_out%0d: got %h expected %h", n, observed(), e);
         end
      end
      valid_in = 1'b0;
      flush_in = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      exp_t e;
      // Push the counter at 0x1000 well into taken before the reset.
      for (int n = 0; n < 3; n++) issue(OP0, 32'd9, 32'd9, 32'h40, 32'h1000, 1'b1, 1'b1, 1'b0, e);
      drive(OP0, 32'd9, 32'd9, 32'h40, 32'h1000, 1'b0, 1'b1, 1'b0);
      tick();
      checks++;
      if (valid_out !== 1'b1 || redirect_out !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: got valid=%b red=%b expected 1 1", valid_out, redirect_out);
      end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++;
      if (valid_out !== 1'b0 || redirect_out !== 1'b0 || observed() !== exp_t'('0)) begin
         errors++;
         $display("FAIL areset_async: got %h expected 0", observed());
      end
      valid_in = 1'b0;
      model_reset();
      #1;
      rstn = 1'b1;
      tick();
      lookup_pc = 32'h1000;
      #1;
      checks++;
      if (lookup_taken !== model_lookup(32'h1000) || observed() !== exp_t'('0)) begin
         errors++;
         $display("FAIL areset_bht: got look=%b out=%h expected look=%b out=0",
                  lookup_taken, observed(), model_lookup(32'h1000));
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_beq_taken();
      test_jalr_misalign();
      test_signed_unsigned();
      test_saturation();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
